// File: rtl/axi_ddr_traffic_gen.sv
// DDR4 AXI4 self-test initiator: writes a burst pattern, reads it back, compares.
// Define TRAFFIC_GEN_LOOP_EN to repeat passes forever with a pulsed done_o.
module axi_ddr_traffic_gen #(
    parameter int          ADDR_WIDTH = 29,
    parameter int          DATA_WIDTH = 64,
    parameter int          BURST_LEN  = 16,
    parameter int          NUM_BURSTS = 64,
    parameter logic [63:0] BASE_ADDR  = 64'd0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    output logic                  aw_valid_o,
    input  logic                  aw_ready_i,
    output logic [ADDR_WIDTH-1:0] aw_addr_o,
    output logic                  w_valid_o,
    input  logic                  w_ready_i,
    output logic [DATA_WIDTH-1:0] w_data_o,
    output logic                  w_last_o,
    input  logic                  b_valid_i,
    output logic                  b_ready_o,
    input  logic [1:0]            b_resp_i,
    output logic                  ar_valid_o,
    input  logic                  ar_ready_i,
    output logic [ADDR_WIDTH-1:0] ar_addr_o,
    input  logic                  r_valid_i,
    output logic                  r_ready_o,
    input  logic [DATA_WIDTH-1:0] r_data_i,
    input  logic [1:0]            r_resp_i,
    input  logic                  r_last_i,
    output logic                  done_o,
    output logic                  error_o,
    output logic [15:0]           err_count_o
);

    typedef enum logic [2:0] {
        IDLE, WR_AW, WR_DATA, WR_RESP, RD_AR, RD_DATA, DONE
    } state_t;

    localparam int LANES = DATA_WIDTH / 32;
    localparam logic [ADDR_WIDTH-1:0] STEP =
        ADDR_WIDTH'(BURST_LEN * (DATA_WIDTH / 8));
    localparam logic [ADDR_WIDTH-1:0] BASE = BASE_ADDR[ADDR_WIDTH-1:0];
    localparam logic [15:0] LAST_BEAT  = 16'(BURST_LEN - 1);
    localparam logic [31:0] LAST_BURST = 32'(NUM_BURSTS - 1);

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [31:0]             burst_q;
    logic [15:0]             beat_q;
    logic [15:0]             pass_q;
    logic [31:0]             lane;
    logic [DATA_WIDTH-1:0]   pat;
    logic                    beat_last;
    logic                    err_evt;

    // The same pattern generator serves write data and read comparison.
    assign lane      = {burst_q[15:0], beat_q} ^ 32'hA5A5_5A5A ^ {16'h0, pass_q};
    assign pat       = {LANES{lane}};
    assign beat_last = (beat_q == LAST_BEAT);

    assign aw_valid_o = (state == WR_AW);
    assign aw_addr_o  = addr_q;
    assign w_valid_o  = (state == WR_DATA);
    assign w_data_o   = w_valid_o ? pat : '0;
    assign w_last_o   = w_valid_o & beat_last;
    assign b_ready_o  = (state == WR_RESP);
    assign ar_valid_o = (state == RD_AR);
    assign ar_addr_o  = addr_q;
    assign r_ready_o  = (state == RD_DATA);
    assign done_o     = (state == DONE);

    assign err_evt =
        (b_ready_o & b_valid_i & (b_resp_i != 2'b00)) |
        (r_ready_o & r_valid_i & ((r_data_i != pat) |
                                  (r_resp_i != 2'b00) |
                                  (r_last_i != beat_last)));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            addr_q      <= '0;
            burst_q     <= '0;
            beat_q      <= '0;
            pass_q      <= '0;
            error_o     <= 1'b0;
            err_count_o <= '0;
        end else begin
            if (err_evt) begin
                error_o <= 1'b1;
                if (err_count_o != 16'hFFFF)
                    err_count_o <= err_count_o + 16'd1;
            end
            unique case (state)
                IDLE: begin
                    if (start_i) begin
                        state   <= WR_AW;
                        addr_q  <= BASE;
                        burst_q <= '0;
                        beat_q  <= '0;
                    end
                end
                WR_AW: begin
                    if (aw_ready_i)
                        state <= WR_DATA;
                end
                WR_DATA: begin
                    if (w_ready_i) begin
                        if (beat_last) begin
                            beat_q <= '0;
                            state  <= WR_RESP;
                        end else begin
                            beat_q <= beat_q + 16'd1;
                        end
                    end
                end
                WR_RESP: begin
                    if (b_valid_i) begin
                        if (burst_q == LAST_BURST) begin
                            burst_q <= '0;
                            addr_q  <= BASE;
                            state   <= RD_AR;
                        end else begin
                            burst_q <= burst_q + 32'd1;
                            addr_q  <= addr_q + STEP;
                            state   <= WR_AW;
                        end
                    end
                end
                RD_AR: begin
                    if (ar_ready_i)
                        state <= RD_DATA;
                end
                RD_DATA: begin
                    // Burst end follows the beat count, not r_last_i.
                    if (r_valid_i) begin
                        if (beat_last) begin
                            beat_q <= '0;
                            if (burst_q == LAST_BURST) begin
                                state <= DONE;
                            end else begin
                                burst_q <= burst_q + 32'd1;
                                addr_q  <= addr_q + STEP;
                                state   <= RD_AR;
                            end
                        end else begin
                            beat_q <= beat_q + 16'd1;
                        end
                    end
                end
                DONE: begin
`ifdef TRAFFIC_GEN_LOOP_EN
                    pass_q  <= pass_q + 16'd1;
                    burst_q <= '0;
                    addr_q  <= BASE;
                    state   <= WR_AW;
`else
                    state   <= DONE;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_ddr_traffic_gen.sv
// Bench for axi_ddr_traffic_gen: random-stall AXI slave, stream monitor,
// scenario table plus reset/idle/loop sequences.
module tb_axi_ddr_traffic_gen;

    localparam int AW = 29;
    localparam int DW = 64;
    localparam int BL = 16;
    localparam int NB = 4;

    logic          clk = 1'b0;
    logic          rst_i, start_i;
    logic          aw_valid, aw_ready, w_valid, w_ready, w_last;
    logic          b_valid, b_ready, ar_valid, ar_ready;
    logic          r_valid, r_ready, r_last, done, error_o;
    logic [AW-1:0] aw_addr, ar_addr;
    logic [DW-1:0] w_data, r_data;
    logic [1:0]    b_resp, r_resp;
    logic [15:0]   err_count;

    always #5 clk = ~clk;

    axi_ddr_traffic_gen #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN(BL),
        .NUM_BURSTS(NB), .BASE_ADDR(64'd0)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
        .aw_valid_o(aw_valid), .aw_ready_i(aw_ready), .aw_addr_o(aw_addr),
        .w_valid_o(w_valid), .w_ready_i(w_ready), .w_data_o(w_data),
        .w_last_o(w_last),
        .b_valid_i(b_valid), .b_ready_o(b_ready), .b_resp_i(b_resp),
        .ar_valid_o(ar_valid), .ar_ready_i(ar_ready), .ar_addr_o(ar_addr),
        .r_valid_i(r_valid), .r_ready_o(r_ready), .r_data_i(r_data),
        .r_resp_i(r_resp), .r_last_i(r_last),
        .done_o(done), .error_o(error_o), .err_count_o(err_count)
    );

    // Fault-injection knobs, written by the test, read by the slave.
    int rdy_pct = 100;
    int flip_b = -1, flip_k = -1, bresp_b = -1, early_b = -1;
    int rresp_b = -1, rresp_k = -1;

    int total = 0;
    int bad   = 0;

    // Reference model: addresses and data from the plain arithmetic rules.
    function automatic logic [AW-1:0] exp_addr(int n);
        return AW'(longint'(n) * BL * (DW / 8));
    endfunction

    function automatic logic [DW-1:0] exp_data(int n, int k, int p);
        logic [31:0] l;
        l = {n[15:0], k[15:0]} ^ 32'hA5A5_5A5A ^ {16'h0, p[15:0]};
        return {(DW / 32){l}};
    endfunction

    function automatic bit rnd();
        return int'($urandom_range(99)) < rdy_pct;
    endfunction

    // AXI slave with a small memory and fault injection.
    logic [DW-1:0] mem [0:255];
    logic [AW-1:0] wr_addr, rd_addr;
    int            wbeat, rbeat, bcnt, arcnt, rburst;
    logic          b_pend, r_act;

    function automatic int midx(logic [AW-1:0] a, int beat);
        return ((int'(a) + beat * (DW / 8)) >> 3) & 255;
    endfunction

    always @(posedge clk) begin
        if (rst_i) begin
            aw_ready <= 1'b0; w_ready <= 1'b0; ar_ready <= 1'b0;
            b_valid <= 1'b0; b_resp <= 2'b00; b_pend <= 1'b0;
            r_valid <= 1'b0; r_data <= '0; r_resp <= 2'b00; r_last <= 1'b0;
            wr_addr <= '0; rd_addr <= '0; r_act <= 1'b0;
            wbeat <= 0; rbeat <= 0; bcnt <= 0; arcnt <= 0; rburst <= 0;
        end else begin
            aw_ready <= rnd();
            w_ready  <= rnd();
            ar_ready <= rnd();
            if (aw_valid && aw_ready) begin
                wr_addr <= aw_addr;
                wbeat   <= 0;
            end
            if (w_valid && w_ready) begin
                mem[midx(wr_addr, wbeat)] <= w_data;
                wbeat <= wbeat + 1;
                if (w_last) b_pend <= 1'b1;
            end
            if (b_valid && b_ready) begin
                b_valid <= 1'b0;
                bcnt    <= bcnt + 1;
            end else if (b_pend && !b_valid) begin
                b_valid <= 1'b1;
                b_pend  <= 1'b0;
                b_resp  <= (bcnt == bresp_b) ? 2'b10 : 2'b00;
            end
            if (ar_valid && ar_ready) begin
                rd_addr <= ar_addr;
                rbeat   <= 0;
                r_act   <= 1'b1;
                rburst  <= arcnt;
                arcnt   <= arcnt + 1;
            end
            if (r_valid && r_ready) begin
                r_valid <= 1'b0;
                rbeat   <= rbeat + 1;
                if (rbeat == BL - 1) r_act <= 1'b0;
            end else if (r_act && !r_valid && rnd()) begin
                r_valid <= 1'b1;
                r_data  <= mem[midx(rd_addr, rbeat)] ^
                           DW'((rburst == flip_b && rbeat == flip_k) ? 1 : 0);
                r_last  <= (rbeat == BL - 1) ||
                           (rburst == early_b && rbeat == BL - 2);
                r_resp  <= (rburst == rresp_b && rbeat == rresp_k) ? 2'b10 : 2'b00;
            end
        end
    end

    // Stream monitor: records handshakes, flags stall instability.
    logic [AW-1:0] aw_q [$];
    logic [AW-1:0] ar_q [$];
    logic [DW:0]   w_q  [$];
    int            r_n, stab_bad, excl_bad, done_n;
    logic          p_aw_st, p_w_st, p_ar_st;
    logic [AW-1:0] p_aw_a, p_ar_a;
    logic [DW:0]   p_w;

    always @(negedge clk) begin
        if (rst_i) begin
            aw_q.delete(); ar_q.delete(); w_q.delete();
            r_n <= 0; stab_bad <= 0; excl_bad <= 0; done_n <= 0;
            p_aw_st <= 1'b0; p_w_st <= 1'b0; p_ar_st <= 1'b0;
            p_aw_a <= '0; p_ar_a <= '0; p_w <= '0;
        end else begin
            if ((p_aw_st && !(aw_valid && aw_addr == p_aw_a)) ||
                (p_w_st && !(w_valid && {w_last, w_data} == p_w)) ||
                (p_ar_st && !(ar_valid && ar_addr == p_ar_a)))
                stab_bad <= stab_bad + 1;
            if ($countones({aw_valid, w_valid, b_ready, ar_valid, r_ready, done}) > 1)
                excl_bad <= excl_bad + 1;
            if (aw_valid && aw_ready) aw_q.push_back(aw_addr);
            if (w_valid && w_ready)   w_q.push_back({w_last, w_data});
            if (ar_valid && ar_ready) ar_q.push_back(ar_addr);
            if (r_valid && r_ready)   r_n <= r_n + 1;
            if (done)                 done_n <= done_n + 1;
            p_aw_st <= aw_valid && !aw_ready;
            p_w_st  <= w_valid && !w_ready;
            p_ar_st <= ar_valid && !ar_ready;
            p_aw_a  <= aw_addr;
            p_ar_a  <= ar_addr;
            p_w     <= {w_last, w_data};
        end
    end

    task automatic check(string name, longint act, longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_i = 1'b0;
    endtask

    task automatic wait_done(int budget);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(posedge clk);
            #1;
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        check("done_timeout", ok, 1);
    endtask

    task automatic verify_stream(int passes, int exp_errs);
        int ba, br, bw, n, k, p;
        check("aw_count", aw_q.size(), NB * passes);
        check("ar_count", ar_q.size(), NB * passes);
        check("w_count", w_q.size(), NB * BL * passes);
        check("r_count", r_n, NB * BL * passes);
        ba = 0; br = 0; bw = 0;
        for (int i = 0; i < aw_q.size(); i++)
            if (aw_q[i] != exp_addr(i % NB)) ba++;
        for (int i = 0; i < ar_q.size(); i++)
            if (ar_q[i] != exp_addr(i % NB)) br++;
        for (int i = 0; i < w_q.size(); i++) begin
            p = i / (NB * BL);
            n = (i / BL) % NB;
            k = i % BL;
            if (w_q[i] != {k == BL - 1, exp_data(n, k, p)}) bw++;
        end
        check("aw_addr_bad", ba, 0);
        check("ar_addr_bad", br, 0);
        check("w_beat_bad", bw, 0);
        check("stall_unstable", stab_bad, 0);
        check("overlap", excl_bad, 0);
        check("error_o", error_o, exp_errs != 0);
        check("err_count", err_count, exp_errs);
    endtask

    typedef struct {
        int pct;
        int flip_b, flip_k, bresp_b, early_b, rresp_b, rresp_k;
        bit drop_start;
        int exp_errs;
    } scen_t;

    scen_t tbl [7];

    initial begin
        int act;
        tbl[0] = '{100, -1, -1, -1, -1, -1, -1, 1'b0, 0};
        tbl[1] = '{100,  2,  3, -1, -1, -1, -1, 1'b0, 1};
        tbl[2] = '{ 50, -1, -1, -1, -1, -1, -1, 1'b1, 0};
        tbl[3] = '{100, -1, -1,  0,  1, -1, -1, 1'b0, 2};
        tbl[4] = '{ 50,  2,  3, -1, -1,  2,  3, 1'b0, 1};
        tbl[5] = '{ 70,  3, 15, -1, -1,  1,  0, 1'b1, 2};
        tbl[6] = '{100, -1, -1,  3, -1, -1, -1, 1'b0, 1};

        start_i = 1'b0;
        do_reset();
        check("rst_aw_valid", aw_valid, 0);
        check("rst_w_valid", w_valid, 0);
        check("rst_b_ready", b_ready, 0);
        check("rst_ar_valid", ar_valid, 0);
        check("rst_r_ready", r_ready, 0);
        check("rst_done", done, 0);
        check("rst_error", error_o, 0);
        check("rst_err_count", err_count, 0);
        check("rst_aw_addr", aw_addr, 0);
        check("rst_w_data", w_data, 0);

        act = 0;
        repeat (100) begin
            @(posedge clk);
            #1;
            if (aw_valid | w_valid | ar_valid | b_ready | r_ready | done) act++;
        end
        check("idle_activity", act, 0);

        start_i = 1'b1;
        @(posedge clk);
        #1;
        check("aw_latency", aw_valid, 1);
        check("aw_first_addr", aw_addr, 0);

        for (int i = 0; i < 7; i++) begin
            rdy_pct = tbl[i].pct;
            flip_b  = tbl[i].flip_b;  flip_k  = tbl[i].flip_k;
            bresp_b = tbl[i].bresp_b; early_b = tbl[i].early_b;
            rresp_b = tbl[i].rresp_b; rresp_k = tbl[i].rresp_k;
            start_i = 1'b1;
            do_reset();
            @(posedge clk);
            #1;
            if (tbl[i].drop_start) start_i = 1'b0;
            wait_done(5000);
            verify_stream(1, tbl[i].exp_errs);
`ifndef TRAFFIC_GEN_LOOP_EN
            repeat (20) @(posedge clk);
            #1;
            check("done_held", done, 1);
            check("quiet_after_done", aw_q.size(), NB);
`endif
        end

        rdy_pct = 100;
        flip_b = -1; flip_k = -1; bresp_b = -1; early_b = -1;
        rresp_b = -1; rresp_k = -1;
        start_i = 1'b1;
        do_reset();
        act = 0;
        while (!(w_q.size() == 5 && w_valid) && act < 2000) begin
            @(posedge clk);
            #1;
            act++;
        end
        check("reach_beat5", act < 2000, 1);
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        check("abort_aw_valid", aw_valid, 0);
        check("abort_w_valid", w_valid, 0);
        check("abort_ar_valid", ar_valid, 0);
        check("abort_done", done, 0);
        rst_i = 1'b0;
        wait_done(5000);
        verify_stream(1, 0);

`ifdef TRAFFIC_GEN_LOOP_EN
        rdy_pct = 60;
        do_reset();
        for (int p = 0; p < 3; p++) wait_done(5000);
        @(negedge clk);
        #1;
        check("loop_done_pulses", done_n, 3);
        verify_stream(3, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
